// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store initiator for the 64x16 data memory
//
// Accepts one load/store at a time, forms eff = base + sext(offset), range
// checks it against MEM_DEPTH and sequences the memory's single-cycle write /
// registered-read port, returning data or an acknowledgement.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_base,
//   req_offset, req_wdata     request fields (offset is 6-bit signed)
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      load data (0 for stores/errors), range error
//   err_cnt                   saturating count of range errors
//   mem_wr_en, mem_rd_en      memory strobes (one cycle each, never together)
//   mem_address, mem_wdata    memory address / write data, held between ops
//   mem_rdata                 memory read data, valid one cycle after mem_rd_en
module dmem_access_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_base,
  input  logic [5:0]        req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [7:0]        err_cnt,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } state_t;

  // One extra bit so a full 16-bit address compares cleanly against the depth.
  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

  state_t      state;
  logic [15:0] eff;
  logic        in_range;

  // Sum wraps modulo 2^16, so base=0xFFFF with offset +1 lands on word 0.
  assign eff      = req_base + {{10{req_offset[5]}}, req_offset};
  assign in_range = ({1'b0, eff} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      err_cnt     <= 8'd0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (!in_range) begin
              // Out-of-range requests never touch the memory pins.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end else begin
              mem_address <= eff[ADDR_W-1:0];
              if (req_we) begin
                mem_wdata <= req_wdata;
                mem_wr_en <= 1'b1;
                state     <= WRITE;
              end else begin
                mem_rd_en <= 1'b1;
                state     <= READ;
              end
            end
          end
        end
        WRITE: begin
          mem_wr_en  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= RESP;
        end
        READ: begin
          // Memory registers its output on this edge; data is usable in RWAIT.
          mem_rd_en <= 1'b0;
          state     <= RWAIT;
        end
        RWAIT: begin
          resp_rdata <= mem_rdata;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_wr_en  <= 1'b0;
          mem_rd_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_base;
  logic [5:0]  req_offset;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  err_cnt;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [5:0]  mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_model [64];
  logic [15:0] ref_mem   [64];
  int          ref_err_cnt = 0;
  logic        dual_seen   = 1'b0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(6), .DATA_W(16), .MEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .err_cnt(err_cnt),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: write on the strobe edge, registered read with 1-cycle latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_address] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_model[mem_address];
  end

  always @(negedge clk) begin
    if (mem_wr_en && mem_rd_en) dual_seen = 1'b1;
  end

  typedef struct {
    logic        we;
    logic [15:0] base;
    logic [5:0]  off;
    logic [15:0] wdata;
    int          hold;
    logic        early;
    logic        err;
    logic [15:0] rdata;
    logic [5:0]  addr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd1);
    check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
    check({tag, "_resp_rdata"},  32'(resp_rdata),  32'd0);
    check({tag, "_resp_err"},    32'(resp_err),    32'd0);
    check({tag, "_err_cnt"},     32'(err_cnt),     32'd0);
    check({tag, "_mem_wr_en"},   32'(mem_wr_en),   32'd0);
    check({tag, "_mem_rd_en"},   32'(mem_rd_en),   32'd0);
    check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_wdata"},   32'(mem_wdata),   32'd0);
  endtask

  // One complete transaction; starts and ends at a negedge with the DUT idle.
  // Expected values come from the table when use_tab is set, else the model.
  task automatic run_txn(input logic we, input logic [15:0] base, input logic [5:0] off,
                         input logic [15:0] wd, input int hold, input logic early,
                         input logic use_tab, input logic t_err, input logic [15:0] t_rdata,
                         input logic [5:0] t_addr);
    int so, e, lat, k, wr_cnt, rd_cnt, wr_k, rd_k;
    logic m_err, e_err, busy_ready, stable;
    logic [5:0]  m_addr, e_addr, addr_seen, rd_addr_seen;
    logic [15:0] m_rdata, e_rdata, wdata_seen, held_rdata;
    logic        held_err;

    so      = off[5] ? int'(off) - 64 : int'(off);
    e       = (int'(base) + so) & 32'hFFFF;
    m_err   = (e >= 64);
    m_addr  = e[5:0];
    m_rdata = (m_err || we) ? 16'h0 : ref_mem[m_addr];
    e_err   = use_tab ? t_err   : m_err;
    e_rdata = use_tab ? t_rdata : m_rdata;
    e_addr  = use_tab ? t_addr  : m_addr;
    lat     = e_err ? 1 : (we ? 2 : 3);
    if (m_err) ref_err_cnt = (ref_err_cnt < 255) ? ref_err_cnt + 1 : 255;
    else if (we) ref_mem[m_addr] = wd;

    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    resp_ready = early;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_base  = 16'($urandom);
    req_wdata = 16'($urandom);

    k = 1; wr_cnt = 0; rd_cnt = 0; wr_k = 0; rd_k = 0;
    addr_seen = '0; rd_addr_seen = '0; wdata_seen = '0; busy_ready = 1'b0;
    while (!resp_valid && k <= 8) begin
      if (mem_wr_en) begin wr_cnt++; wr_k = k; addr_seen = mem_address; wdata_seen = mem_wdata; end
      if (mem_rd_en) begin rd_cnt++; rd_k = k; rd_addr_seen = mem_address; end
      if (req_ready) busy_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en) rd_cnt++;
    if (req_ready) busy_ready = 1'b1;

    check("resp_latency", 32'(k), 32'(lat));
    check("wr_strobe_count", 32'(wr_cnt), (we && !e_err) ? 32'd1 : 32'd0);
    check("rd_strobe_count", 32'(rd_cnt), (!we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) begin
      check("wr_strobe_cycle", 32'(wr_k), 32'd1);
      check("wr_address", 32'(addr_seen), 32'(e_addr));
      check("wr_data", 32'(wdata_seen), 32'(wd));
    end
    if (!we && !e_err) begin
      check("rd_strobe_cycle", 32'(rd_k), 32'd1);
      check("rd_address", 32'(rd_addr_seen), 32'(e_addr));
    end
    check("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("err_cnt", 32'(err_cnt), 32'(ref_err_cnt));
    check("busy_req_ready", 32'(busy_ready), 32'd0);

    // Backpressure: a competing request is offered but must not be taken.
    if (hold > 0) begin
      stable     = 1'b1;
      held_rdata = resp_rdata;
      held_err   = resp_err;
      for (int i = 0; i < hold; i++) begin
        req_valid  = 1'b1;
        req_we     = 1'($urandom);
        req_offset = 6'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (!resp_valid || resp_rdata !== held_rdata || resp_err !== held_err ||
            req_ready || mem_wr_en || mem_rd_en) stable = 1'b0;
      end
      req_valid = 1'b0;
      check("backpressure_stable", 32'(stable), 32'd1);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp_req_ready", 32'(req_ready), 32'd1);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic reset_in_read(input logic [15:0] base, input logic [5:0] off);
    logic quiet;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_base   = base;
    req_offset = off;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_rd_strobe", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_err_cnt = 0;
    check_reset_outputs("rst_read");
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid || mem_wr_en || mem_rd_en || !req_ready) quiet = 1'b1 & 1'b0;
    end
    check("rst_no_response", 32'(quiet), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_model[i] = 16'h0;
      ref_mem[i]   = 16'h0;
    end
    mem_rdata  = 16'h0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_base   = 16'h0;
    req_offset = 6'h0;
    req_wdata  = 16'h0;
    resp_ready = 1'b0;

    vecs[0]  = '{1'b1, 16'd10,   6'h05, 16'hBEEF, 0, 1'b0, 1'b0, 16'h0000, 6'd15};
    vecs[1]  = '{1'b1, 16'd0,    6'h0F, 16'h1234, 0, 1'b0, 1'b0, 16'h0000, 6'd15};
    vecs[2]  = '{1'b0, 16'd20,   6'h3B, 16'h0000, 5, 1'b0, 1'b0, 16'h1234, 6'd15};
    vecs[3]  = '{1'b0, 16'd60,   6'h04, 16'h0000, 0, 1'b0, 1'b1, 16'h0000, 6'd0};
    vecs[4]  = '{1'b1, 16'hFFFF, 6'h01, 16'hA5A5, 0, 1'b0, 1'b0, 16'h0000, 6'd0};
    vecs[5]  = '{1'b1, 16'd63,   6'h00, 16'h7777, 0, 1'b0, 1'b0, 16'h0000, 6'd63};
    vecs[6]  = '{1'b0, 16'h0040, 6'h3F, 16'h0000, 2, 1'b0, 1'b0, 16'h7777, 6'd63};
    vecs[7]  = '{1'b1, 16'hFFFF, 6'h3F, 16'h1111, 0, 1'b0, 1'b1, 16'h0000, 6'd0};
    vecs[8]  = '{1'b0, 16'd3,    6'h20, 16'h0000, 0, 1'b0, 1'b1, 16'h0000, 6'd0};
    vecs[9]  = '{1'b0, 16'd0,    6'h00, 16'h0000, 0, 1'b1, 1'b0, 16'hA5A5, 6'd0};
    vecs[10] = '{1'b1, 16'd5,    6'h03, 16'hCAFE, 0, 1'b1, 1'b0, 16'h0000, 6'd8};
    vecs[11] = '{1'b0, 16'd8,    6'h00, 16'h0000, 0, 1'b1, 1'b0, 16'hCAFE, 6'd8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].base, vecs[i].off, vecs[i].wdata, vecs[i].hold,
              vecs[i].early, 1'b1, vecs[i].err, vecs[i].rdata, vecs[i].addr);
    end

    for (int n = 0; n < 150; n++) begin
      logic [15:0] b;
      int          h;
      logic        er;
      b  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 80));
      h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      er = (h == 0) ? 1'($urandom) : 1'b0;
      run_txn(1'($urandom), b, 6'($urandom), 16'($urandom), h, er, 1'b0, 1'b0, 16'h0, 6'h0);
    end

    for (int n = 0; n < 300; n++) begin
      run_txn(1'b0, 16'd60, 6'h04, 16'h0, 0, 1'b1, 1'b0, 1'b0, 16'h0, 6'h0);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    reset_in_read(16'd8, 6'h00);
    run_txn(1'b0, 16'd8, 6'h00, 16'h0, 0, 1'b0, 1'b1, 1'b0, ref_mem[8], 6'd8);

    check("no_dual_strobe", 32'(dual_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
